// File: rtl/aes_spi_scheduler.sv
// Two-requester SPI front end for a pair of AES slaves: streams key then block to the
// granted slave, idles while it computes, then shifts the 128-bit result back in.
module aes_spi_scheduler #(
    parameter int NK          = 8,
    parameter int WAIT_CYCLES = 56
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [32*NK-1:0] key0,
    input  logic [32*NK-1:0] key1,
    input  logic [127:0]     blk0,
    input  logic [127:0]     blk1,
    output logic [1:0]       cs_n,
    output logic             mosi,
    input  logic             miso,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic [127:0]     result,
    output logic [2:0]       state_dbg
);
    localparam int KB = 32 * NK;
    localparam int SW = KB + 128;
    localparam logic [15:0] KEY_LAST  = 16'(KB - 1);
    localparam logic [15:0] BLK_LAST  = 16'd127;
    localparam logic [15:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 16'(WAIT_CYCLES - 1) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_KEY, S_SEND_BLK, S_WAIT, S_RECV, S_DONE
    } state_t;

    state_t        state, state_n;
    logic [15:0]   cnt;
    logic [SW-1:0] sh;
    logic          grant, prio, pick, cnt_zero;
    logic [1:0]    cs_sel;

    assign cnt_zero  = (cnt == 16'd0);
    // prio names the requester that wins a tie; it flips to the other one after each grant
    assign pick      = (req0 && req1) ? prio : req1;
    assign cs_sel    = grant ? 2'b01 : 2'b10;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        cs_n    = 2'b11;
        mosi    = 1'b0;
        busy    = (state != S_IDLE);
        done0   = 1'b0;
        done1   = 1'b0;
        case (state)
            S_IDLE: if (req0 || req1) state_n = S_SEND_KEY;
            S_SEND_KEY: begin
                cs_n = cs_sel;
                mosi = sh[SW-1];
                if (cnt_zero) state_n = S_SEND_BLK;
            end
            S_SEND_BLK: begin
                cs_n = cs_sel;
                mosi = sh[SW-1];
                if (cnt_zero) state_n = (WAIT_CYCLES > 0) ? S_WAIT : S_RECV;
            end
            S_WAIT: begin
                cs_n = cs_sel;
                if (cnt_zero) state_n = S_RECV;
            end
            S_RECV: begin
                cs_n = cs_sel;
                if (cnt_zero) state_n = S_DONE;
            end
            S_DONE: begin
                done0   = ~grant;
                done1   = grant;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One shift register carries key+block out, then collects the result in its low bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            sh     <= '0;
            grant  <= 1'b0;
            prio   <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        grant <= pick;
                        prio  <= ~pick;
                        sh    <= pick ? {key1, blk1} : {key0, blk0};
                        cnt   <= KEY_LAST;
                    end
                end
                S_SEND_KEY: begin
                    sh  <= {sh[SW-2:0], 1'b0};
                    cnt <= cnt_zero ? BLK_LAST : cnt - 16'd1;
                end
                S_SEND_BLK: begin
                    sh  <= {sh[SW-2:0], 1'b0};
                    cnt <= cnt_zero ? ((WAIT_CYCLES > 0) ? WAIT_LAST : BLK_LAST) : cnt - 16'd1;
                end
                S_WAIT: cnt <= cnt_zero ? BLK_LAST : cnt - 16'd1;
                S_RECV: begin
                    sh  <= {sh[SW-2:0], miso};
                    cnt <= cnt_zero ? cnt : cnt - 16'd1;
                    if (cnt_zero) result <= {sh[126:0], miso};
                end
                default: ;
            endcase
        end
    end
endmodule
